sbox_sched: RTL and testbench

SBOX_SCHED -- requirements
Module: sbox_sched

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/sbox.sv | 13 +
 rtl/sbox_sched.sv | 124 ++++++++++++
 tb/tb_sbox_sched.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, default job sizes and GF(2^8) helpers for the AES S-box scheduler.
package aes_pkg;

  localparam int NB_DATA_DEF = 16;
  localparam int NB_KEY_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_DATA = 2'd2
  } sched_state_t;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    logic       hi;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] aes_affine(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

endpackage

// File: rtl/sbox.sv
// Combinational AES S-box: field inverse followed by the affine map.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  always_comb begin
    s = aes_affine(gf_inv(a));
  end

endmodule

// File: rtl/sbox_sched.sv
// Time-shares one S-box between a key requester (SubWord) and a data requester
// (SubBytes), one byte per cycle; key jobs win at job boundaries, no preemption.
module sbox_sched
  import aes_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_KEY  = NB_KEY_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   d_start,
  input  logic [8*NB_DATA-1:0]   d_in,
  output logic                   d_rdy,
  output logic                   d_done,
  output logic [8*NB_DATA-1:0]   d_out,
  input  logic                   k_start,
  input  logic [8*NB_KEY-1:0]    k_in,
  output logic                   k_rdy,
  output logic                   k_done,
  output logic [8*NB_KEY-1:0]    k_out
);

  localparam int CW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam int KW = (NB_KEY > 1) ? $clog2(NB_KEY) : 1;

  sched_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic k_pend, d_pend;
  logic k_acc, d_acc;
  logic k_last, d_last;
  logic k_take, d_take;
  logic boundary;

  logic [8*NB_KEY-1:0]  k_sh, k_work, k_work_nx, k_out_r;
  logic [8*NB_DATA-1:0] d_sh, d_work, d_work_nx, d_out_r;
  logic k_done_r, d_done_r;

  logic [KW-1:0] k_idx;
  logic [7:0]    sb_in, sb_out;

  assign k_rdy  = ~k_pend & (state != ST_KEY);
  assign d_rdy  = ~d_pend & (state != ST_DATA);
  assign k_acc  = k_start & k_rdy;
  assign d_acc  = d_start & d_rdy;
  assign k_last = (state == ST_KEY)  && (cnt == CW'(NB_KEY - 1));
  assign d_last = (state == ST_DATA) && (cnt == CW'(NB_DATA - 1));

  assign k_done = k_done_r;
  assign d_done = d_done_r;
  assign k_out  = k_out_r;
  assign d_out  = d_out_r;

  // A request accepted this very cycle can start at the same edge, so an
  // idle scheduler begins the job on the cycle right after acceptance.
  always_comb begin
    state_nx = state;
    k_take   = 1'b0;
    d_take   = 1'b0;
    boundary = (state == ST_IDLE) | k_last | d_last;
    if (boundary) begin
      if (k_pend | k_acc) begin
        state_nx = ST_KEY;
        k_take   = 1'b1;
      end else if (d_pend | d_acc) begin
        state_nx = ST_DATA;
        d_take   = 1'b1;
      end else begin
        state_nx = ST_IDLE;
      end
    end
  end

  assign k_idx = cnt[KW-1:0];

  always_comb begin
    sb_in = 8'h00;
    if (state == ST_KEY)       sb_in = k_sh[8*k_idx +: 8];
    else if (state == ST_DATA) sb_in = d_sh[8*cnt +: 8];
  end

  sbox u_sbox (
    .a (sb_in),
    .s (sb_out)
  );

  always_comb begin
    k_work_nx = k_work;
    d_work_nx = d_work;
    if (state == ST_KEY)  k_work_nx[8*k_idx +: 8] = sb_out;
    if (state == ST_DATA) d_work_nx[8*cnt +: 8]   = sb_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      k_pend   <= 1'b0;
      d_pend   <= 1'b0;
      k_sh     <= '0;
      d_sh     <= '0;
      k_work   <= '0;
      d_work   <= '0;
      k_out_r  <= '0;
      d_out_r  <= '0;
      k_done_r <= 1'b0;
      d_done_r <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= boundary ? '0 : cnt + CW'(1);
      k_pend   <= (k_pend | k_acc) & ~k_take;
      d_pend   <= (d_pend | d_acc) & ~d_take;
      if (k_acc) k_sh <= k_in;
      if (d_acc) d_sh <= d_in;
      k_work   <= k_work_nx;
      d_work   <= d_work_nx;
      // Visible results change only together with the done pulse.
      if (k_last) k_out_r <= k_work_nx;
      if (d_last) d_out_r <= d_work_nx;
      k_done_r <= k_last;
      d_done_r <= d_last;
    end
  end

endmodule

// File: tb/tb_sbox_sched.sv
// Directed bench for sbox_sched: vector table of single jobs plus hand-written
// sequences for arbitration, back-to-back requests and mid-job reset.
module tb_sbox_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         d_start;
  logic [127:0] d_in;
  logic         d_rdy;
  logic         d_done;
  logic [127:0] d_out;
  logic         k_start;
  logic [31:0]  k_in;
  logic         k_rdy;
  logic         k_done;
  logic [31:0]  k_out;

  int n_vec = 0;
  int n_bad = 0;

  logic [127:0] exp_d_out;
  logic [31:0]  exp_k_out;

  typedef struct {
    logic         is_key;
    logic [127:0] din;
    logic [127:0] dexp;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  sbox_sched #(.NB_DATA(16), .NB_KEY(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .d_start (d_start),
    .d_in    (d_in),
    .d_rdy   (d_rdy),
    .d_done  (d_done),
    .d_out   (d_out),
    .k_start (k_start),
    .k_in    (k_in),
    .k_rdy   (k_rdy),
    .k_done  (k_done),
    .k_out   (k_out)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs ncyc cycles from a negedge. Cycle 0 is the cycle in which starts
  // are driven; every later cycle checks done, rdy and held outputs.
  task automatic window(input string nm, input int ncyc,
                        input int ka, input logic [31:0] kv, input int kd, input logic [31:0] kexp,
                        input int da, input int dlast, input logic [127:0] dv, input logic [127:0] dv2,
                        input int dd, input logic [127:0] dexp, input int dd2, input logic [127:0] dexp2);
    for (int n = 0; n <= ncyc; n++) begin
      if (n > 0) begin
        if (n == kd)  exp_k_out = kexp;
        if (n == dd)  exp_d_out = dexp;
        if (n == dd2) exp_d_out = dexp2;
        chk($sformatf("%s c%0d k_done", nm, n), {127'b0, k_done}, {127'b0, (n == kd)});
        chk($sformatf("%s c%0d d_done", nm, n), {127'b0, d_done}, {127'b0, (n == dd) || (n == dd2)});
        chk($sformatf("%s c%0d k_rdy", nm, n), {127'b0, k_rdy},
            {127'b0, !(ka >= 0 && n > ka && n < kd)});
        chk($sformatf("%s c%0d d_rdy", nm, n), {127'b0, d_rdy},
            {127'b0, !((da >= 0 && n > da && n < dd) || (dd2 > 0 && n > dd && n < dd2))});
        chk($sformatf("%s c%0d k_out", nm, n), {96'b0, k_out}, {96'b0, exp_k_out});
        chk($sformatf("%s c%0d d_out", nm, n), d_out, exp_d_out);
      end
      k_start = (n == ka);
      k_in    = (n == ka) ? kv : ~kv;
      d_start = (da >= 0 && n >= da && n <= dlast);
      d_in    = (n == da) ? dv : dv2;
      @(posedge clk);
      @(negedge clk);
    end
    k_start = 1'b0;
    d_start = 1'b0;
  endtask

  initial begin
    logic [127:0] all53, allED, all63, seq_in, seq_exp;
    all53   = {16{8'h53}};
    allED   = {16{8'hED}};
    all63   = {16{8'h63}};
    seq_in  = 128'h0f0e0d0c0b0a09080706050403020100;
    seq_exp = 128'h76abd7fe2b670130c56f6bf27b777c63;

    tbl[0] = '{1'b1, 128'h00000000, 128'h63636363};
    tbl[1] = '{1'b1, 128'h01FF5300, 128'h7C16ED63};
    tbl[2] = '{1'b1, 128'hFFFFFFFF, 128'h16161616};
    tbl[3] = '{1'b1, 128'h10200203, 128'hCAB7777B};
    tbl[4] = '{1'b1, 128'h80AA8080, 128'hCDACCDCD};
    tbl[5] = '{1'b0, all53, allED};
    tbl[6] = '{1'b0, seq_in, seq_exp};

    rst     = 1'b1;
    d_start = 1'b0;
    k_start = 1'b0;
    d_in    = '0;
    k_in    = '0;
    exp_d_out = '0;
    exp_k_out = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("reset d_rdy", {127'b0, d_rdy}, 128'd1);
    chk("reset k_rdy", {127'b0, k_rdy}, 128'd1);
    chk("reset d_done", {127'b0, d_done}, 128'd0);
    chk("reset k_done", {127'b0, k_done}, 128'd0);
    chk("reset d_out", d_out, 128'd0);
    chk("reset k_out", {96'b0, k_out}, 128'd0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].is_key)
        window($sformatf("vec%0d key", i), 6, 0, tbl[i].din[31:0], 5, tbl[i].dexp[31:0],
               -1, -1, '0, '0, 0, '0, 0, '0);
      else
        window($sformatf("vec%0d data", i), 18, -1, 32'h0, 0, 32'h0,
               0, 0, tbl[i].din, ~tbl[i].din, 17, tbl[i].dexp, 0, '0);
    end

    // Both requesters in the same cycle: key first, data right behind it.
    window("simul", 22, 0, 32'hFFFFFFFF, 5, 32'h16161616,
           0, 0, '0, all53, 21, all63, 0, '0);

    // Key arrives while data runs and waits for the data job to finish.
    window("key_wait", 22, 3, 32'h01FF5300, 21, 32'h7C16ED63,
           0, 0, seq_in, all53, 17, seq_exp, 0, '0);

    // d_start held high: only one job runs, the second is taken in the done cycle.
    window("held", 36, -1, 32'h0, 0, 32'h0,
           0, 17, all53, seq_in, 17, allED, 34, seq_exp);

    // Reset in the middle of a data job, with both starts asserted alongside rst.
    d_start = 1'b1;
    d_in    = seq_in;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      d_start = 1'b0;
    end
    chk("midjob d_rdy", {127'b0, d_rdy}, 128'd0);
    rst     = 1'b1;
    k_start = 1'b1;
    d_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    k_start = 1'b0;
    d_start = 1'b0;
    exp_d_out = '0;
    exp_k_out = '0;
    window("post_rst", 20, -1, 32'h0, 0, 32'h0,
           -1, -1, '0, '0, 0, '0, 0, '0);
    window("after_rst key", 6, 0, 32'h01FF5300, 5, 32'h7C16ED63,
           -1, -1, '0, '0, 0, '0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
